// File: rtl/sd_adder_chunk_sequencer.sv
// sd_adder_chunk_sequencer
//   Runs one CHUNK_DIGITS-wide radix-2 signed-digit (borrow-save) adder over NUM_CHUNKS
//   chunks of wide operands. Chunks are processed least-significant first, one per cycle.
//   The chunk carry-out is registered and becomes the next chunk's carry-in.
//
// Optional feature macro: SDSEQ_ACC_EN
//   When it is defined, accepting an op with i_acc=1 loads operand B from the current
//   sum registers. When it is undefined, i_acc is ignored.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_in_valid / o_in_ready operand handshake; ready only while idle
//   i_a_p, i_a_n            operand A digits (value = p - n per digit)
//   i_b_p, i_b_n            operand B digits
//   i_cin                   carry into chunk 0
//   i_acc                   accumulate select (SDSEQ_ACC_EN builds only)
//   o_out_valid/i_out_ready result handshake; result held while valid
//   o_sum_p, o_sum_n        result digits
//   o_cout                  carry out of the top chunk
//   o_busy                  high while running or holding a result
module sd_adder_chunk_sequencer #(
  parameter int unsigned CHUNK_DIGITS = 8,
  parameter int unsigned NUM_CHUNKS   = 4,
  parameter int unsigned CNT_W        = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  input  logic [CHUNK_DIGITS*NUM_CHUNKS-1:0] i_a_p,
  input  logic [CHUNK_DIGITS*NUM_CHUNKS-1:0] i_a_n,
  input  logic [CHUNK_DIGITS*NUM_CHUNKS-1:0] i_b_p,
  input  logic [CHUNK_DIGITS*NUM_CHUNKS-1:0] i_b_n,
  input  logic                               i_cin,
  input  logic                               i_acc,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [CHUNK_DIGITS*NUM_CHUNKS-1:0] o_sum_p,
  output logic [CHUNK_DIGITS*NUM_CHUNKS-1:0] o_sum_n,
  output logic                               o_cout,
  output logic                               o_busy
);

  localparam int unsigned TOTAL = CHUNK_DIGITS * NUM_CHUNKS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_cout;
  logic [TOTAL-1:0]   r_a_p, r_a_n, r_b_p, r_b_n;
  logic [TOTAL-1:0]   r_sum_p, r_sum_n;

  logic [31:0]             w_base;
  logic [CHUNK_DIGITS-1:0] w_ap, w_an, w_bp, w_bn;
  logic [CHUNK_DIGITS-1:0] w_h, w_t, w_hin, w_s, w_g;
  logic [CHUNK_DIGITS-1:0] w_dout_p, w_dout_n;
  logic                    w_cout;

  // ---------------------------------------------------------------------------
  // Chunk adder (carry-free, two full-adder levels)
  // ---------------------------------------------------------------------------
  assign w_base = 32'(r_idx) * CHUNK_DIGITS;
  assign w_ap   = r_a_p[w_base +: CHUNK_DIGITS];
  assign w_an   = r_a_n[w_base +: CHUNK_DIGITS];
  assign w_bp   = r_b_p[w_base +: CHUNK_DIGITS];
  assign w_bn   = r_b_n[w_base +: CHUNK_DIGITS];

  // Level 1: a_p + b_p - a_n = 2*h - t per digit.
  assign w_h = (w_ap & w_bp) | (w_ap & ~w_an) | (w_bp & ~w_an);
  assign w_t = w_ap ^ w_bp ^ w_an;

  // Level 2: h(i-1) - t - b_n = s - 2*g per digit; chunk carry-in enters as h(-1).
  assign w_hin = (w_h << 1) | CHUNK_DIGITS'(r_carry);
  assign w_s   = w_hin ^ w_t ^ w_bn;
  assign w_g   = (~w_hin & w_t) | (~w_hin & w_bn) | (w_t & w_bn);

  // Digit i is (s(i), g(i-1)); the negative slot of digit 0 is always empty.
  assign w_dout_p = w_s;
  assign w_dout_n = w_g << 1;

  // The top transfer is h - g. With a non-negative chunk sum it is 0 or 1, and h=g=1
  // cancels, so a single positive carry bit is exact.
  assign w_cout = w_h[CHUNK_DIGITS-1] & ~w_g[CHUNK_DIGITS-1];

`ifndef SDSEQ_ACC_EN
  logic w_unused_acc;
  assign w_unused_acc = i_acc;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cout      <= 1'b0;
      r_a_p       <= '0;
      r_a_n       <= '0;
      r_b_p       <= '0;
      r_b_n       <= '0;
      r_sum_p     <= '0;
      r_sum_n     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid && r_in_ready) begin
            r_a_p <= i_a_p;
            r_a_n <= i_a_n;
`ifdef SDSEQ_ACC_EN
            if (i_acc) begin
              r_b_p <= r_sum_p;
              r_b_n <= r_sum_n;
            end else begin
              r_b_p <= i_b_p;
              r_b_n <= i_b_n;
            end
`else
            r_b_p <= i_b_p;
            r_b_n <= i_b_n;
`endif
            r_carry    <= i_cin;
            r_idx      <= '0;
            r_state    <= StRun;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StRun: begin
          r_sum_p[w_base +: CHUNK_DIGITS] <= w_dout_p;
          r_sum_n[w_base +: CHUNK_DIGITS] <= w_dout_n;
          r_carry                         <= w_cout;
          // The index holds on the last chunk, so it never leaves 0..NUM_CHUNKS-1.
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_cout;
            r_state     <= StDone;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + CNT_W'(1);
          end
        end
        StDone: begin
          if (i_out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_sum_p     = r_sum_p;
  assign o_sum_n     = r_sum_n;
  assign o_cout      = r_cout;

endmodule
